// File: rtl/mult_pkg.sv
// Shared types and constants for the Booth multiplier front end.
package mult_pkg;

  localparam int unsigned OP_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone
  } cap_state_t;

endpackage

// File: rtl/sw_operand_capture_if.sv
// Operand/handshake bundle between the switch capture stage and the multiplier side.
interface sw_operand_capture_if;
  import mult_pkg::*;

  logic [2*OP_W-1:0] sw;
  logic              mult_busy;
  logic [OP_W-1:0]   mc;
  logic [OP_W-1:0]   mp;
  logic              start;
  logic              pending;

  modport master (
    input  sw,
    input  mult_busy,
    output mc,
    output mp,
    output start,
    output pending
  );

  modport slave (
    output sw,
    output mult_busy,
    input  mc,
    input  mp,
    input  start,
    input  pending
  );

endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debouncer for the slide switches.
// SW_DEBOUNCE_EN selects the debouncer; without it db follows the synchroniser directly.
module sw_debounce #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_db
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_cand;
  logic [CntW-1:0]  r_cnt;

  // Counter saturates at CntMax; db keeps reloading the same settled value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_db   <= '0;
    end else if (r_s2 != r_cand) begin
      r_cand <= r_s2;
      r_cnt  <= '0;
    end else if (r_cnt == CntMax) begin
      r_db <= r_cand;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db <= '0;
    end else begin
      r_db <= r_s2;
    end
  end
`endif

  assign o_db = r_db;

endmodule

// File: rtl/sw_operand_capture.sv
// Latches a debounced operand pair from the switches and issues one start per distinct value.
// Debounce is enabled inside sw_debounce by SW_DEBOUNCE_EN.
module sw_operand_capture
  import mult_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned ACK_TIMEOUT     = 15
) (
  input logic                  clk,
  input logic                  reset,
  sw_operand_capture_if.master bus
);

  localparam int unsigned ToW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(ACK_TIMEOUT - 1);

  cap_state_t        r_state;
  cap_state_t        w_state_d;
  logic [2*OP_W-1:0] w_db;
  logic [OP_W-1:0]   r_mc;
  logic [OP_W-1:0]   r_mp;
  logic              r_start;
  logic              r_first;
  logic [ToW-1:0]    r_to;
  logic              w_pending;

  sw_debounce #(
    .WIDTH          (2 * OP_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .i_sw (bus.sw),
    .o_db (w_db)
  );

  assign w_pending = (w_db != {r_mp, r_mc}) | r_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (w_pending && !bus.mult_busy) w_state_d = StIssue;
      StIssue:    w_state_d = StWaitAck;
      // An abandoned handshake leaves {mp,mc} equal to db, so it is not re-issued.
      StWaitAck: begin
        if (bus.mult_busy)       w_state_d = StWaitDone;
        else if (r_to == ToLast) w_state_d = StIdle;
      end
      StWaitDone: if (!bus.mult_busy) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mc    <= '0;
      r_mp    <= '0;
      r_start <= 1'b0;
      r_first <= 1'b1;
      r_to    <= '0;
    end else begin
      r_start <= 1'b0;
      if (r_state == StIdle && w_state_d == StIssue) begin
        {r_mp, r_mc} <= w_db;
        r_start      <= 1'b1;
        r_first      <= 1'b0;
      end
      if (r_state == StWaitAck) r_to <= r_to + ToW'(1);
      else                      r_to <= '0;
    end
  end

  always_comb begin
    bus.mc      = r_mc;
    bus.mp      = r_mp;
    bus.start   = r_start;
    bus.pending = w_pending;
  end

endmodule

// File: tb/tb_sw_operand_capture.sv
// Randomised bench for sw_operand_capture against a settled-value / handshake reference model.
module tb_sw_operand_capture;

  localparam int DC   = 4;
  localparam int AT   = 15;
  localparam int MAXE = 8192;
`ifdef SW_DEBOUNCE_EN
  localparam int LAT           = DC + 4;
  localparam int BOUNCE_STARTS = 0;
`else
  localparam int LAT           = 4;
  localparam int BOUNCE_STARTS = 2;
`endif

  logic clk;
  logic reset;

  sw_operand_capture_if bus_if ();

  sw_operand_capture #(
    .DEBOUNCE_CYCLES(DC),
    .ACK_TIMEOUT    (AT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int n_starts;
  int edge_n;

  // Per-edge history since the last reset release: sampled sw, synchronised sw, settled value.
  logic [15:0] samp [MAXE];
  logic [15:0] s2a  [MAXE];
  logic [15:0] setl [MAXE];
  logic [15:0] m_p;
  bit          m_first;
  bit          m_free;
  bit          m_acked;
  bit          m_start;
  int          m_issue_at;

  bit resp_en;
  bit force_busy;
  int ack_delay;
  int busy_len;
  int wait_cnt;
  int hold_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
    end
  endtask

  task automatic model_reset();
    edge_n  = 0;
    samp[0] = '0;
    s2a[0]  = '0;
    setl[0] = '0;
    m_p     = '0;
    m_first = 1'b1;
    m_free  = 1'b1;
    m_acked = 1'b0;
    m_start = 1'b0;
  endtask

  task automatic model_edge(input logic [15:0] sw_in, input logic busy_in);
    bit stable;
    int n;
    edge_n++;
    n = edge_n;
    if (n >= MAXE) begin
      $display("FAIL model_range: edge %0d beyond history %0d", n, MAXE);
      $fatal(1);
    end
    samp[n] = sw_in;
    s2a[n]  = samp[n-1];
`ifdef SW_DEBOUNCE_EN
    // Settled once the synchronised value held for DC+1 consecutive edges.
    stable = (n >= DC + 1);
    for (int k = n - 1 - DC; k <= n - 1 && stable; k++)
      if (s2a[k] != s2a[n-1]) stable = 1'b0;
    setl[n] = stable ? s2a[n-1] : setl[n-1];
`else
    stable  = 1'b1;
    setl[n] = s2a[n-1];
`endif
    m_start = 1'b0;
    if (m_free) begin
      if (((setl[n-1] != m_p) || m_first) && !busy_in) begin
        m_p        = setl[n-1];
        m_first    = 1'b0;
        m_free     = 1'b0;
        m_acked    = 1'b0;
        m_issue_at = n;
        m_start    = 1'b1;
      end
    end else if (!m_acked) begin
      if (n >= m_issue_at + 2) begin
        if (busy_in)                      m_acked = 1'b1;
        else if (n == m_issue_at + 1 + AT) m_free  = 1'b1;
      end
    end else if (!busy_in) begin
      m_free = 1'b1;
    end
  endtask

  task automatic cycle();
    logic [15:0] sw_now;
    logic        busy_now;
    bus_if.mult_busy = force_busy || (wait_cnt == 0 && hold_cnt > 0);
    sw_now   = bus_if.sw;
    busy_now = bus_if.mult_busy;
    @(posedge clk);
    model_edge(sw_now, busy_now);
    #1;
    check("start", 32'(bus_if.start), 32'(m_start));
    check("mc", 32'(bus_if.mc), 32'(m_p[7:0]));
    check("mp", 32'(bus_if.mp), 32'(m_p[15:8]));
    check("pending", 32'(bus_if.pending), 32'((setl[edge_n] != m_p) || m_first));
    if (bus_if.start === 1'b1) n_starts++;
    if (bus_if.start === 1'b1 && resp_en) begin
      wait_cnt = ack_delay;
      hold_cnt = busy_len;
    end else if (wait_cnt > 0) begin
      wait_cnt--;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_start(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc && at < 0; i++) begin
      cycle();
      if (bus_if.start === 1'b1) at = edge_n;
    end
    check("start_seen", 32'(bus_if.start), 32'(1));
  endtask

  int at;
  int e0;
  int s0;
  int r;
  int hold;
  logic [15:0] keep;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    n_starts   = 0;
    resp_en    = 1'b1;
    force_busy = 1'b0;
    ack_delay  = 0;
    busy_len   = 2;
    wait_cnt   = 0;
    hold_cnt   = 0;
    bus_if.sw        = '0;
    bus_if.mult_busy = 1'b0;
    reset = 1'b1;
    model_reset();

    // Reset state, then the power-up 0x0 issue on the first edge.
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", 32'(bus_if.start), 32'(0));
    check("rst_mc", 32'(bus_if.mc), 32'(0));
    check("rst_mp", 32'(bus_if.mp), 32'(0));
    check("rst_pending", 32'(bus_if.pending), 32'(1));
    reset = 1'b0;
    cycle();
    check("powerup_start", 32'(bus_if.start), 32'(1));
    idle(20);

    // Stable change with a 10-cycle busy response.
    busy_len  = 10;
    e0        = edge_n;
    bus_if.sw = 16'h0305;
    wait_start(40, at);
    check("stable_lat", 32'(at - e0), 32'(LAT));
    check("stable_mc", 32'(bus_if.mc), 32'(8'h05));
    check("stable_mp", 32'(bus_if.mp), 32'(8'h03));
    s0 = n_starts;
    idle(25);
    check("stable_one_pulse", 32'(n_starts - s0), 32'(0));
    check("stable_pending", 32'(bus_if.pending), 32'(0));

    // Short glitch to FFFF.
    s0        = n_starts;
    bus_if.sw = 16'hFFFF;
    idle(3);
    bus_if.sw = 16'h0305;
    idle(30);
    check("bounce_starts", 32'(n_starts - s0), 32'(BOUNCE_STARTS));
    check("bounce_mc", 32'(bus_if.mc), 32'(8'h05));
    check("bounce_mp", 32'(bus_if.mp), 32'(8'h03));

    // Two changes while the multiplier is busy collapse into one issue.
    busy_len  = 20;
    bus_if.sw = 16'h2233;
    wait_start(40, at);
    idle(2);
    bus_if.sw = 16'h0102;
    idle(6);
    bus_if.sw = 16'h0A0B;
    s0 = n_starts;
    wait_start(60, at);
    check("busy_mc", 32'(bus_if.mc), 32'(8'h0B));
    check("busy_mp", 32'(bus_if.mp), 32'(8'h0A));
    idle(30);
    check("busy_single_start", 32'(n_starts - s0), 32'(1));

    // No acknowledge: the next issue can only follow the timeout.
    resp_en   = 1'b0;
    bus_if.sw = 16'h5A5A;
    wait_start(40, e0);
    bus_if.sw = 16'hA5A5;
    wait_start(60, at);
    check("ack_timeout_lat", 32'(at - e0), 32'(AT + 2));
    check("ack_timeout_mc", 32'(bus_if.mc), 32'(8'hA5));
    s0 = n_starts;
    idle(30);
    check("ack_timeout_no_reissue", 32'(n_starts - s0), 32'(0));
    resp_en = 1'b1;
    idle(5);

    // Reset mid-operation with busy held across the release.
    busy_len  = 30;
    bus_if.sw = 16'h1234;
    wait_start(40, at);
    idle(3);
    #2;
    reset            = 1'b1;
    force_busy       = 1'b1;
    bus_if.mult_busy = 1'b1;
    wait_cnt         = 0;
    hold_cnt         = 0;
    bus_if.sw        = '0;
    #1;
    check("midrst_start", 32'(bus_if.start), 32'(0));
    check("midrst_mc", 32'(bus_if.mc), 32'(0));
    check("midrst_mp", 32'(bus_if.mp), 32'(0));
    check("midrst_pending", 32'(bus_if.pending), 32'(1));
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    s0    = n_starts;
    idle(5);
    check("busy_release_hold", 32'(n_starts - s0), 32'(0));
    force_busy = 1'b0;
    e0         = edge_n;
    wait_start(10, at);
    check("busy_release_lat", 32'(at - e0), 32'(1));
    check("busy_release_mc", 32'(bus_if.mc), 32'(0));
    check("busy_release_mp", 32'(bus_if.mp), 32'(0));
    idle(40);

    // Random switch activity and bus responses.
    for (int it = 0; it < 150; it++) begin
      r          = $urandom_range(0, 99);
      hold       = $urandom_range(1, 20);
      ack_delay  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      busy_len   = $urandom_range(0, 8);
      force_busy = ($urandom_range(0, 14) == 0);
      if (r < 50) begin
        bus_if.sw = 16'($urandom);
      end else if (r < 75) begin
        keep      = bus_if.sw;
        bus_if.sw = 16'($urandom);
        repeat ($urandom_range(1, DC)) cycle();
        bus_if.sw = keep;
      end
      repeat (hold) cycle();
    end
    force_busy = 1'b0;
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
